// File: rtl/dist_1x2_simple_seq.sv
// Sequential 1-to-2 distributor: routes one input word stream to the low,
// high or both branches, or alternately between them via a round-robin bit.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_valid      : input word valid
//   i_data_bus   : input word
//   i_en         : block enable; when low, outputs go invalid and data holds
//   i_cmd        : routing command, bits [1:0] decoded
//                  (00 low, 01 high, 10 broadcast, 11 alternate)
//   o_valid      : per-branch valid, [1] high, [0] low
//   o_data_bus   : {high word, low word}, all outputs registered
module dist_1x2_simple_seq #(
    parameter int DATA_WIDTH    = 32,
    parameter int COMMAND_WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_valid,
    input  logic [DATA_WIDTH-1:0]    i_data_bus,
    input  logic                     i_en,
    input  logic [COMMAND_WIDTH-1:0] i_cmd,
    output logic [1:0]               o_valid,
    output logic [2*DATA_WIDTH-1:0]  o_data_bus
);

    typedef enum logic [1:0] {
        CMD_LOW   = 2'b00,
        CMD_HIGH  = 2'b01,
        CMD_BCAST = 2'b10,
        CMD_ALT   = 2'b11
    } cmd_e;

    logic [1:0]            valid_q, valid_d;
    logic [DATA_WIDTH-1:0] lo_q, lo_d;
    logic [DATA_WIDTH-1:0] hi_q, hi_d;
    logic                  rr_q, rr_d;
    cmd_e                  cmd;

    assign cmd = cmd_e'(i_cmd[1:0]);

    always_comb begin
        // Disabled cycles: drop valid, keep data and pointer.
        valid_d = 2'b00;
        lo_d    = lo_q;
        hi_d    = hi_q;
        rr_d    = rr_q;
        if (i_en) begin
            // Enabled: any branch not written below carries zero.
            lo_d = '0;
            hi_d = '0;
            if (i_valid) begin
                unique case (cmd)
                    CMD_LOW: begin
                        valid_d = 2'b01;
                        lo_d    = i_data_bus;
                    end
                    CMD_HIGH: begin
                        valid_d = 2'b10;
                        hi_d    = i_data_bus;
                    end
                    CMD_BCAST: begin
                        valid_d = 2'b11;
                        lo_d    = i_data_bus;
                        hi_d    = i_data_bus;
                    end
                    CMD_ALT: begin
                        rr_d = ~rr_q;
                        if (rr_q) begin
                            valid_d = 2'b10;
                            hi_d    = i_data_bus;
                        end else begin
                            valid_d = 2'b01;
                            lo_d    = i_data_bus;
                        end
                    end
                    default: begin
                        valid_d = 2'b00;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 2'b00;
            lo_q    <= '0;
            hi_q    <= '0;
            rr_q    <= 1'b0;
        end else begin
            valid_q <= valid_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            rr_q    <= rr_d;
        end
    end

    assign o_valid    = valid_q;
    assign o_data_bus = {hi_q, lo_q};

endmodule

// File: doc/dist_1x2_simple_seq.md
Name: dist_1x2_simple_seq

Overview:
- Sequential 1-to-2 distributor. It is the fan-out counterpart of the 2x1 merge node in the NoC tree.
- One input data stream is routed to the low branch, the high branch, both branches, or alternately between them, as selected by i_cmd.
- Outputs are registered, with a round-robin pointer for alternate mode.
- Data format passes through unchanged. Dummy data is {DATA_WIDTH{1'b0}}.

Parameters:
- DATA_WIDTH, 32, width of one data word.
- COMMAND_WIDTH, 2, width of i_cmd. Must be >= 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- i_valid  input  1  input word valid.
- i_data_bus  input  DATA_WIDTH  input data word.
- i_en  input  1  block enable.
- i_cmd  input  COMMAND_WIDTH  routing command; only bits [1:0] are decoded.
- o_valid  output  2  per-branch valid: [1] = high branch, [0] = low branch.
- o_data_bus  output  2*DATA_WIDTH  branch data. High branch = [2*DATA_WIDTH-1:DATA_WIDTH], low branch = [DATA_WIDTH-1:0].

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - o_valid=2'b00, o_data_bus=0.
  - Round-robin pointer rr_ptr=0, meaning the next alternate word goes to the low branch.
  - Outputs stay at these values while rst_n=0, regardless of the other inputs.
- Latency: one cycle. Inputs sampled at edge N appear on the outputs after edge N and stay stable until edge N+1.
- Command decode, applied when i_en=1 and i_valid=1 at the edge:
  - 2'b00 (low): o_valid=2'b01, low=i_data_bus, high=0.
  - 2'b01 (high): o_valid=2'b10, high=i_data_bus, low=0.
  - 2'b10 (broadcast): o_valid=2'b11, both branches=i_data_bus.
  - 2'b11 (alternate):
    - rr_ptr=0: behaves as low.
    - rr_ptr=1: behaves as high.
    - rr_ptr toggles at the same edge.
- rr_ptr changes only on an alternate-mode transfer. Commands 00/01/10, idle cycles and disabled cycles leave it unchanged.
- i_en=1, i_valid=0: o_valid=2'b00 and o_data_bus=0 at the next edge. rr_ptr holds.
- i_en=0:
  - o_valid=2'b00 at the next edge.
  - o_data_bus holds its previous value.
  - rr_ptr holds.
  - i_valid and i_cmd are ignored, and the input word is dropped (no buffering).
- Valid-only protocol: there is no backpressure, and every accepted word is emitted exactly once (twice in broadcast mode).
- A non-selected branch always carries o_valid=0 with data 0. The exception is the i_en=0 hold case, where data holds.
- Command change mid-stream takes effect on the very next sampled word. There are no pipeline bubbles, and the rr_ptr state is preserved across mode switches.
- Deasserting rst_n mid-stream discards the in-flight word. The first word after release of reset follows the normal rules with rr_ptr=0.
- No combinational path from any input to any output; all outputs are flops.

Test Plan:
- Reset: rst_n=0 with i_valid=1, i_en=1, i_data_bus=32'hAAAAAAAA → o_valid=2'b00 and o_data_bus=64'h0 immediately and throughout reset.
- Directed routing: i_en=1, i_valid=1, i_data_bus=32'hAAAAAAAA, i_cmd=00 then 01 then 10 on consecutive cycles → o_valid is 01, 10, 11 one cycle later each:
  - cycle 1: o_data_bus = 64'h00000000_AAAAAAAA.
  - cycle 2: o_data_bus = 64'hAAAAAAAA_00000000.
  - cycle 3: o_data_bus = 64'hAAAAAAAA_AAAAAAAA.
- Alternate: i_cmd=11, four consecutive words 32'h1, 32'h2, 32'h3, 32'h4 → o_valid sequence 01, 10, 01, 10, with data 1 on low, 2 on high, 3 on low, 4 on high.
- Pointer persistence:
  - Send i_cmd=11 once (goes low), then i_cmd=00 twice, then an idle cycle (i_valid=0), then i_cmd=11 with 32'hBBBBBBBB.
  - Required: the last word goes to the high branch with o_valid=2'b10. During the idle cycle, o_valid=00 and data=0.
- Disable mid-stream:
  - After a low transfer of 32'hAAAAAAAA, set i_en=0 for two cycles with i_valid=1, i_data_bus=32'hBBBBBBBB.
  - Required: o_valid=00 and o_data_bus holds 64'h00000000_AAAAAAAA.
  - On re-enable with i_cmd=01, 32'hBBBBBBBB appears on the high branch only.
- Reset mid-alternate: send two alternate words, then pulse rst_n low between edges.
  - Required: outputs clear asynchronously.
  - The next alternate word after release goes to the low branch (rr_ptr=0).
